td_multiplier: RTL and testbench



---
 rtl/td_multiplier.sv | 61 ++++++
 tb/tb_td_multiplier.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/td_multiplier.sv
// Time-domain constant-coefficient multiplier: each sample becomes a pulse whose width is the sample.
// The pulse is integrated COEFF units per cycle, and the product is published at every frame boundary.
module td_multiplier #(
  parameter int T_DEL = 4,
  parameter int COEFF = 1,
  parameter int N_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BIT-1:0] in,
  output logic [N_BIT-1:0] out,
  output logic             t,
  output logic             offset0_out,
  output logic             offset1_out,
  output logic             offset2_out,
  output logic [N_BIT-1:0] inner_clk,
  output logic [N_BIT-1:0] inner_in
);

  localparam int                 DLY_W     = 3 * T_DEL;
  localparam int                 ACC_W     = 2 * N_BIT;
  localparam logic [N_BIT-1:0]   LAST_PH   = '1;
  localparam logic [N_BIT-1:0]   PH_STEP   = N_BIT'(1);
  localparam logic [ACC_W-1:0]   COEFF_EXT = ACC_W'(COEFF);

  logic [ACC_W-1:0] acc_p0;
  logic [DLY_W-1:0] dly_p0;

  // Product is published modulo 2^N_BIT; wrap-around is intended, no saturation.
  function automatic logic [N_BIT-1:0] trunc_prod(input logic [ACC_W-1:0] p);
    return N_BIT'(p);
  endfunction

  assign t           = (inner_clk < inner_in);
  assign offset0_out = dly_p0[T_DEL-1];
  assign offset1_out = dly_p0[2*T_DEL-1];
  assign offset2_out = dly_p0[3*T_DEL-1];

  // Stage p0: phase counter, pulse integration, frame-boundary publish and tap shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      inner_clk <= '0;
      inner_in  <= '0;
      acc_p0    <= '0;
      out       <= '0;
      dly_p0    <= '0;
    end else begin
      inner_clk <= inner_clk + PH_STEP;
      dly_p0    <= {dly_p0[DLY_W-2:0], t};
      if (inner_clk == LAST_PH) begin
        // t is always low at the last phase, so nothing is lost by clearing here.
        out      <= trunc_prod(acc_p0);
        acc_p0   <= '0;
        inner_in <= in;
      end else if (t) begin
        acc_p0 <= acc_p0 + COEFF_EXT;
      end
    end
  end

endmodule

// File: tb/tb_td_multiplier.sv
// Directed bench for td_multiplier: three instances (COEFF 1, 5, 0) share clock, reset and input.
// Products are queued when a sample is taken at a boundary and compared one frame later.
module tb_td_multiplier;

  localparam int N_BIT = 4;
  localparam int T_DEL = 4;
  localparam int F     = 16;
  localparam int ND    = 3;
  localparam int CO [ND] = '{1, 5, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_drv = '0;

  logic [3:0] out_w [ND];
  logic       t_w   [ND];
  logic       o0_w  [ND];
  logic       o1_w  [ND];
  logic       o2_w  [ND];
  logic [3:0] ic_w  [ND];
  logic [3:0] ii_w  [ND];

  td_multiplier #(.T_DEL(T_DEL), .COEFF(1), .N_BIT(N_BIT)) dut_c1 (
    .clk(clk), .rst(rst), .in(in_drv), .out(out_w[0]), .t(t_w[0]),
    .offset0_out(o0_w[0]), .offset1_out(o1_w[0]), .offset2_out(o2_w[0]),
    .inner_clk(ic_w[0]), .inner_in(ii_w[0]));

  td_multiplier #(.T_DEL(T_DEL), .COEFF(5), .N_BIT(N_BIT)) dut_c5 (
    .clk(clk), .rst(rst), .in(in_drv), .out(out_w[1]), .t(t_w[1]),
    .offset0_out(o0_w[1]), .offset1_out(o1_w[1]), .offset2_out(o2_w[1]),
    .inner_clk(ic_w[1]), .inner_in(ii_w[1]));

  td_multiplier #(.T_DEL(T_DEL), .COEFF(0), .N_BIT(N_BIT)) dut_c0 (
    .clk(clk), .rst(rst), .in(in_drv), .out(out_w[2]), .t(t_w[2]),
    .offset0_out(o0_w[2]), .offset1_out(o1_w[2]), .offset2_out(o2_w[2]),
    .inner_clk(ic_w[2]), .inner_in(ii_w[2]));

  always #5 clk = ~clk;

  int         total  = 0;
  int         passed = 0;
  int         n      = 0;
  logic [3:0] cur_v  = '0;
  logic [3:0] exp_out [ND];
  logic [3:0] sb [ND][$];
  logic       hist [0:2047];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d edge%0d observed=%0d expected=%0d", tag, k, n, obs, exp);
  endtask

  function automatic logic tap_exp(input int d);
    return (n >= d) ? hist[n-d] : 1'b0;
  endfunction

  task automatic check_all();
    logic et;
    et = (n % F) < int'(cur_v);
    for (int k = 0; k < ND; k++) begin
      chk("inner_clk", k, 32'(ic_w[k]), 32'(n % F));
      chk("inner_in",  k, 32'(ii_w[k]), 32'(cur_v));
      chk("t",         k, 32'(t_w[k]),  32'(et));
      chk("out",       k, 32'(out_w[k]), 32'(exp_out[k]));
      chk("offset0",   k, 32'(o0_w[k]), 32'(tap_exp(T_DEL)));
      chk("offset1",   k, 32'(o1_w[k]), 32'(tap_exp(2*T_DEL)));
      chk("offset2",   k, 32'(o2_w[k]), 32'(tap_exp(3*T_DEL)));
    end
  endtask

  task automatic step();
    logic [3:0] in_s;
    in_s = in_drv;
    @(posedge clk);
    #1;
    n++;
    if (n % F == 0) begin
      for (int k = 0; k < ND; k++) begin
        if (sb[k].size() == 0) begin
          total++;
          $error("FAIL scoreboard_empty dut%0d edge%0d observed=0 expected=1", k, n);
        end else begin
          exp_out[k] = sb[k].pop_front();
        end
        sb[k].push_back(4'((int'(in_s) * CO[k]) % F));
      end
      cur_v = in_s;
    end
    hist[n] = (n % F) < int'(cur_v);
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < F; i++) begin
      if (n % F == ph) break;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_out",       k, 32'(out_w[k]), 32'd0);
      chk("rst_t",         k, 32'(t_w[k]),   32'd0);
      chk("rst_offset0",   k, 32'(o0_w[k]),  32'd0);
      chk("rst_offset1",   k, 32'(o1_w[k]),  32'd0);
      chk("rst_offset2",   k, 32'(o2_w[k]),  32'd0);
      chk("rst_inner_clk", k, 32'(ic_w[k]),  32'd0);
      chk("rst_inner_in",  k, 32'(ii_w[k]),  32'd0);
      sb[k].delete();
      sb[k].push_back(4'd0);
      exp_out[k] = 4'd0;
    end
    n       = 0;
    cur_v   = '0;
    hist[0] = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    in_drv = 4'd4;
    do_reset();
    // basic: in=4 through two full frames after the first boundary
    run(48);
    // overflow: 7*5 = 35 -> 3 on the COEFF=5 instance
    in_drv = 4'd7;
    run(32);
    // full-scale sample: t must stay low at the last phase
    in_drv = 4'd15;
    run(32);
    // mid-frame input change is ignored until the next boundary
    in_drv = 4'd4;
    run(16);
    run_to_phase(5);
    in_drv = 4'd9;
    run(40);
    // narrow pulse to watch the three taps
    in_drv = 4'd2;
    run(48);
    // reset at phase 8 of a frame carrying in=6; the partial product must vanish
    in_drv = 4'd6;
    run(16);
    run_to_phase(8);
    do_reset();
    run(40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
